// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter (reverse double-dabble); optional digit check via BCD_TO_BIN_CHECK_EN
module bcd_to_bin_seq #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DIGITS*4-1:0]   bcd_in,
   output logic                  ready,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int WORK_W = DIGITS*4 + BIN_W;
   localparam int CNT_W  = $clog2(BIN_W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [WORK_W-1:0]   work_q, work_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [BIN_W-1:0]    bin_out_q, bin_out_d;
   logic                err_q, err_d;
   logic                done_q, done_d;

   logic [WORK_W-1:0]   work_shift;
   logic [WORK_W-1:0]   work_corr;

`ifdef BCD_TO_BIN_CHECK_EN
   function automatic logic has_bad_digit(input logic [DIGITS*4-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction
`endif

   // One reverse double-dabble step: shift right, then pull each BCD nibble >= 8 back by 3
   always_comb begin
      work_shift = work_q >> 1;
      work_corr  = work_shift;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_shift[BIN_W + 4*i +: 4] >= 4'd8) begin
            work_corr[BIN_W + 4*i +: 4] = work_shift[BIN_W + 4*i +: 4] - 4'd3;
         end
      end
   end

   // Next-state and next-output logic for the IDLE/CONV/DONE sequence
   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      bin_out_d = bin_out_q;
      err_d     = err_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
`ifdef BCD_TO_BIN_CHECK_EN
               if (has_bad_digit(bcd_in)) begin
                  state_d   = S_DONE;
                  bin_out_d = '0;
                  err_d     = 1'b1;
                  done_d    = 1'b1;
               end else begin
                  state_d = S_CONV;
                  work_d  = {bcd_in, {BIN_W{1'b0}}};
                  cnt_d   = '0;
               end
`else
               state_d = S_CONV;
               work_d  = {bcd_in, {BIN_W{1'b0}}};
               cnt_d   = '0;
`endif
            end
         end
         S_CONV: begin
            work_d = work_corr;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d   = S_DONE;
               bin_out_d = work_corr[BIN_W-1:0];
               err_d     = 1'b0;
               done_d    = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous active-high reset
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= S_IDLE;
         work_q    <= '0;
         cnt_q     <= '0;
         bin_out_q <= '0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
         err_q     <= err_d;
         done_q    <= done_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign done    = done_q;
   assign bin_out = bin_out_q;
   assign err     = err_q;

endmodule
